// File: rtl/ula_arbiter_if.sv
// Bundle between the ULA arbiter, its requesters, the shared ULA and the response consumer.
//   req/req_opcode/req_a/req_b : per-port requests, port i packed at [8i+7:8i] / [Wi+W-1:Wi]
//   gnt                        : one-hot, one-cycle capture pulse back to the requester
//   alu_*                      : operands out to the shared ULA, result/flags back
//   rsp_*                      : registered response with valid/ready handshake
//   busy                       : arbiter is not idle
// The arbiter connects through the slave modport; the environment uses master.
interface ula_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_opcode;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        alu_opcode;
  logic [W-1:0]      alu_operand1;
  logic [W-1:0]      alu_operand2;
  logic [W-1:0]      alu_result;
  logic [7:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_result;
  logic [7:0]        rsp_flags;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req, req_opcode, req_a, req_b, alu_result, alu_flags, rsp_ready,
    output gnt, alu_opcode, alu_operand1, alu_operand2,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy
  );

  modport master (
    output req, req_opcode, req_a, req_b, alu_result, alu_flags, rsp_ready,
    input  gnt, alu_opcode, alu_operand1, alu_operand2,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA among NREQ (=4) requesters.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : ula_arbiter_if.slave (requests, grant, ULA drive/return, response, busy)
// Flow: IDLE picks a winner and latches its operands (gnt pulses), EXEC drives the
// ULA for one cycle and captures its outputs, RESP holds the response until accepted.
module ula_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) (
  input logic         clk,
  input logic         reset,
  ula_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      id_q, id_d;
  logic            err_q, err_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      alu_op_q, alu_op_d;
  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_result_q, rsp_result_d;
  logic [7:0]      rsp_flags_q, rsp_flags_d;
  logic            rsp_err_q, rsp_err_d;

  // Round-robin pick: first requesting port starting at last_q + 1, wrapping.
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = last_q + 2'(i + 1);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Winner's fields and the error decode on them.
  logic [7:0]   sel_op;
  logic [W-1:0] sel_a, sel_b;
  logic         sel_err;
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == 2'(i)) begin
        sel_op = bus.req_opcode[i*8 +: 8];
        sel_a  = bus.req_a[i*W +: W];
        sel_b  = bus.req_b[i*W +: W];
      end
    end
    sel_err = (sel_op == 8'h00) || (sel_op > 8'h0C) ||
              (((sel_op == 8'h04) || (sel_op == 8'h05)) && (sel_b == '0));
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    err_d        = err_q;
    gnt_d        = '0;
    alu_op_d     = '0;
    alu_a_d      = '0;
    alu_b_d      = '0;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StExec;
          last_d     = win;
          id_d       = win;
          err_d      = sel_err;
          gnt_d[win] = 1'b1;
          // An erroneous opcode is never presented to the ULA.
          alu_op_d   = sel_err ? 8'h00 : sel_op;
          alu_a_d    = sel_a;
          alu_b_d    = sel_b;
        end
      end
      StExec: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = err_q;
        if (err_q) begin
          rsp_result_d = '0;
          rsp_flags_d  = 8'h01;
        end else begin
          rsp_result_d = bus.alu_result;
          rsp_flags_d  = bus.alu_flags;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_q       <= 2'(NREQ - 1);
      id_q         <= '0;
      err_q        <= 1'b0;
      gnt_q        <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      err_q        <= err_d;
      gnt_q        <= gnt_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.alu_opcode   = alu_op_q;
  assign bus.alu_operand1 = alu_a_q;
  assign bus.alu_operand2 = alu_b_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_flags    = rsp_flags_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: a transaction-level model predicts every output
// each cycle; directed scenarios add literal expectations; then randomized traffic.
module tb_ula_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ula_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
  ula_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Stand-in ULA: returns {flags, result}.
  function automatic logic [15:0] ula(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] r;
    case (op)
      8'h01:   r = a + b;
      8'h02:   r = a - b;
      8'h03:   r = a & b;
      8'h04:   r = (b != 0) ? a / b : 8'h00;
      8'h05:   r = (b != 0) ? a % b : 8'h00;
      8'h06:   r = a | b;
      8'h07:   r = a ^ b;
      default: r = a + b + op;
    endcase
    return {op[3:0], 2'b00, r[7], (r == 8'h00), r};
  endfunction

  assign {bus.alu_flags, bus.alu_result} = ula(bus.alu_opcode, bus.alu_operand1,
                                               bus.alu_operand2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_phase;  // 0 waiting for requests, 1 operation issued, 2 response out
  int         m_last, m_win;
  logic       m_err;
  logic [7:0] m_op, m_a, m_b;
  logic [3:0] e_gnt;
  logic [7:0] e_alu_op, e_a, e_b, e_res, e_flg;
  logic       e_rv, e_err;
  logic [1:0] e_id;
  int         t_w, t_p;
  bit         t_found, t_bad;
  logic [7:0] t_op, t_a, t_b;
  logic [15:0] t_u;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0; m_last <= NREQ - 1;
      e_gnt <= '0; e_alu_op <= '0; e_a <= '0; e_b <= '0;
      e_rv <= 1'b0; e_id <= '0; e_res <= '0; e_flg <= '0; e_err <= 1'b0;
    end else begin
      e_gnt <= '0; e_alu_op <= '0; e_a <= '0; e_b <= '0;
      if (m_phase == 0) begin
        t_found = 1'b0;
        t_w     = 0;
        for (int k = 1; k <= NREQ; k++) begin
          t_p = (m_last + k) % NREQ;
          if (!t_found && bus.req[t_p]) begin
            t_found = 1'b1;
            t_w     = t_p;
          end
        end
        if (t_found) begin
          t_op  = bus.req_opcode[t_w*8 +: 8];
          t_a   = bus.req_a[t_w*8 +: 8];
          t_b   = bus.req_b[t_w*8 +: 8];
          t_bad = (t_op == 0) || (t_op > 12) || ((t_op == 4 || t_op == 5) && t_b == 0);
          m_phase <= 1; m_last <= t_w; m_win <= t_w;
          m_op <= t_op; m_a <= t_a; m_b <= t_b; m_err <= t_bad;
          e_gnt    <= 4'(1 << t_w);
          e_alu_op <= t_bad ? 8'h00 : t_op;
          e_a      <= t_a;
          e_b      <= t_b;
        end
      end else if (m_phase == 1) begin
        m_phase <= 2;
        e_rv    <= 1'b1;
        e_id    <= 2'(m_win);
        e_err   <= m_err;
        if (m_err) begin
          e_res <= 8'h00;
          e_flg <= 8'h01;
        end else begin
          t_u   = ula(m_op, m_a, m_b);
          e_res <= t_u[7:0];
          e_flg <= t_u[15:8];
        end
      end else if (bus.rsp_ready) begin
        m_phase <= 0;
        e_rv    <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", 32'(bus.gnt), 32'(e_gnt));
      check("alu_opcode", 32'(bus.alu_opcode), 32'(e_alu_op));
      check("alu_operand1", 32'(bus.alu_operand1), 32'(e_a));
      check("alu_operand2", 32'(bus.alu_operand2), 32'(e_b));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      check("busy", 32'(bus.busy), 32'(m_phase != 0));
      if (e_rv) begin
        check("rsp_id", 32'(bus.rsp_id), 32'(e_id));
        check("rsp_result", 32'(bus.rsp_result), 32'(e_res));
        check("rsp_flags", 32'(bus.rsp_flags), 32'(e_flg));
        check("rsp_err", 32'(bus.rsp_err), 32'(e_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_port(input int i, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b);
    bus.req_opcode[i*8 +: 8] = op;
    bus.req_a[i*8 +: 8]      = a;
    bus.req_b[i*8 +: 8]      = b;
    bus.req[i]               = 1'b1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req       = '0;
    bus.rsp_ready = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.req        = '0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    // Reset values
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'h0);
    check("rst_rsp_flags", 32'(bus.rsp_flags), 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_alu_opcode", 32'(bus.alu_opcode), 32'h0);
    reset = 1'b0;

    // Single add on port 0: gnt at N+1, response at N+2
    set_port(0, 8'h01, 8'h05, 8'h03);
    cyc(1);
    check("add_gnt", 32'(bus.gnt), 32'h1);
    check("add_alu_opcode", 32'(bus.alu_opcode), 32'h1);
    bus.req[0] = 1'b0;
    cyc(1);
    check("add_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("add_rsp_result", 32'(bus.rsp_result), 32'h08);
    check("add_rsp_id", 32'(bus.rsp_id), 32'h0);
    check("add_rsp_err", 32'(bus.rsp_err), 32'h0);
    cyc(1);
    check("add_rsp_done", 32'(bus.rsp_valid), 32'h0);

    // All four ports continuously: grants 0,1,2,3,0 every third cycle
    do_reset();
    for (int i = 0; i < 4; i++) set_port(i, 8'h01, 8'(i), 8'h10);
    for (int t = 1; t <= 15; t++) begin
      cyc(1);
      check($sformatf("rr_gnt_t%0d", t), 32'(bus.gnt),
            (t % 3 == 1) ? (32'h1 << (((t - 1) / 3) % 4)) : 32'h0);
    end
    bus.req = '0;
    cyc(3);

    // Divide by zero on port 2
    do_reset();
    set_port(2, 8'h04, 8'h09, 8'h00);
    cyc(1);
    check("div0_gnt", 32'(bus.gnt), 32'h4);
    check("div0_alu_opcode", 32'(bus.alu_opcode), 32'h0);
    bus.req[2] = 1'b0;
    cyc(1);
    check("div0_rsp_err", 32'(bus.rsp_err), 32'h1);
    check("div0_rsp_result", 32'(bus.rsp_result), 32'h0);
    check("div0_rsp_flags", 32'(bus.rsp_flags), 32'h01);
    check("div0_rsp_id", 32'(bus.rsp_id), 32'h2);

    // Bad opcode on port 1 with port 3 waiting behind it
    do_reset();
    set_port(1, 8'h0D, 8'h01, 8'h02);
    set_port(3, 8'h01, 8'h04, 8'h04);
    cyc(1);
    check("badop_gnt", 32'(bus.gnt), 32'h2);
    bus.req[1] = 1'b0;
    cyc(1);
    check("badop_rsp_err", 32'(bus.rsp_err), 32'h1);
    check("badop_rsp_id", 32'(bus.rsp_id), 32'h1);
    cyc(1);
    check("badop_idle_gnt", 32'(bus.gnt), 32'h0);
    cyc(1);
    check("badop_next_gnt", 32'(bus.gnt), 32'h8);
    bus.req[3] = 1'b0;
    cyc(1);
    check("badop_next_result", 32'(bus.rsp_result), 32'h08);
    check("badop_next_err", 32'(bus.rsp_err), 32'h0);

    // Backpressure: response held five cycles, port 3 waits
    do_reset();
    bus.rsp_ready = 1'b0;
    set_port(0, 8'h02, 8'h09, 8'h04);
    set_port(3, 8'h03, 8'h0F, 8'h33);
    cyc(1);
    check("bp_gnt", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    for (int t = 0; t < 5; t++) begin
      cyc(1);
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_hold_result", 32'(bus.rsp_result), 32'h05);
      check("bp_hold_gnt", 32'(bus.gnt), 32'h0);
    end
    bus.rsp_ready = 1'b1;
    cyc(1);
    check("bp_release_valid", 32'(bus.rsp_valid), 32'h0);
    check("bp_release_gnt", 32'(bus.gnt), 32'h0);
    cyc(1);
    check("bp_port3_gnt", 32'(bus.gnt), 32'h8);
    bus.req[3] = 1'b0;
    cyc(1);
    check("bp_port3_result", 32'(bus.rsp_result), 32'h03);

    // Reset during EXEC discards the operation and restores port 0 priority
    do_reset();
    set_port(2, 8'h01, 8'h01, 8'h01);
    cyc(1);
    check("rx_gnt", 32'(bus.gnt), 32'h4);
    bus.req[2] = 1'b0;
    reset = 1'b1;
    cyc(1);
    check("rx_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rx_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_port(i, 8'h07, 8'h0F, 8'h0A);
    cyc(1);
    check("rx_first_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    cyc(3);

    // Randomized traffic
    do_reset();
    for (int t = 0; t < 600; t++) begin
      cyc(1);
      reset         = ($urandom_range(0, 149) == 0);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (bus.gnt[i]) bus.req[i] = 1'b0;
        else if (bus.req[i]) begin
          if ($urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_port(i, 8'($urandom_range(0, 14)), 8'($urandom),
                   ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        end
      end
    end
    reset   = 1'b0;
    bus.req = '0;
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
